// File: rtl/qsram_access_scheduler.sv
// Purpose: arbitrates requesters A/B onto the SDR QSRAM pins and inserts periodic refresh commands.
// Latency: Ack and the command appear the cycle after the grant; read data returns READ_LATENCY+1 cycles after the command.
// Backpressure: requesters hold Req until Ack; requests wait while a command, read wait or refresh is in progress.
module qsram_access_scheduler #(
    parameter int ADDR_WIDTH       = 30,
    parameter int DATA_WIDTH       = 9,
    parameter int REFRESH_INTERVAL = 780,
    parameter int REFRESH_CYCLES   = 4,
    parameter int READ_LATENCY     = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqA,
    input  logic                  ReqB,
    input  logic                  WriteA,
    input  logic                  WriteB,
    input  logic [ADDR_WIDTH-1:0] AddrA,
    input  logic [ADDR_WIDTH-1:0] AddrB,
    input  logic [DATA_WIDTH-1:0] WDataA,
    input  logic [DATA_WIDTH-1:0] WDataB,
    output logic                  AckA,
    output logic                  AckB,
    output logic [DATA_WIDTH-1:0] RDataA,
    output logic [DATA_WIDTH-1:0] RDataB,
    output logic                  RValidA,
    output logic                  RValidB,
    output logic                  MemEnable,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  MemRefresh,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemDataOut,
    output logic                  MemDataOE,
    input  logic [DATA_WIDTH-1:0] MemDataIn,
    output logic                  Busy,
    output logic                  RefreshOverrun
);

    localparam int TIMER_W = $clog2(REFRESH_INTERVAL);
    localparam int RCNT_W  = $clog2(REFRESH_CYCLES + 1);
    localparam int LAT_W   = $clog2(READ_LATENCY + 1);

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(REFRESH_INTERVAL - 1);
    localparam logic [RCNT_W-1:0]  RCNT_LOAD    = RCNT_W'(REFRESH_CYCLES - 1);
    localparam logic [LAT_W-1:0]   LAT_LOAD     = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ      = 3'd2,
        S_READ_WAIT = 3'd3,
        S_REFRESH   = 3'd4
    } state_t;

    state_t                  state;
    logic [TIMER_W-1:0]      ref_timer;
    logic                    ref_pending;
    logic [RCNT_W-1:0]       ref_cnt;
    logic [LAT_W-1:0]        lat_cnt;
    logic                    favour_b;
    logic                    rd_port_b;

    logic                    refresh_start;
    logic                    grant_a;
    logic                    grant_b;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // Refresh beats requesters; with both requesting, the port not served last wins.
    always_comb begin
        refresh_start = 1'b0;
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        if (state == S_IDLE) begin
            refresh_start = ref_pending;
            grant_a       = !ref_pending && ReqA && (!ReqB || !favour_b);
            grant_b       = !ref_pending && ReqB && (!ReqA || favour_b);
        end
        sel_write = grant_a ? WriteA : WriteB;
        sel_addr  = grant_a ? AddrA  : AddrB;
        sel_wdata = grant_a ? WDataA : WDataB;
    end

    assign Busy = (state != S_IDLE);

    // Free-running refresh interval timer; a second expiry while the first is still unserved is an overrun.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ref_timer      <= TIMER_RELOAD;
            ref_pending    <= 1'b0;
            RefreshOverrun <= 1'b0;
        end else begin
            if (ref_timer == '0) begin
                ref_timer   <= TIMER_RELOAD;
                ref_pending <= 1'b1;
                // The pending refresh being taken this very cycle is not an overrun.
                if (ref_pending && !refresh_start) begin
                    RefreshOverrun <= 1'b1;
                end
            end else begin
                ref_timer <= ref_timer - TIMER_W'(1);
                if (refresh_start) begin
                    ref_pending <= 1'b0;
                end
            end
        end
    end

    // Access sequencer: all pin outputs are registered and default to 0 outside command cycles.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            ref_cnt    <= '0;
            lat_cnt    <= '0;
            favour_b   <= 1'b0;
            rd_port_b  <= 1'b0;
            AckA       <= 1'b0;
            AckB       <= 1'b0;
            RDataA     <= '0;
            RDataB     <= '0;
            RValidA    <= 1'b0;
            RValidB    <= 1'b0;
            MemEnable  <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            MemRefresh <= 1'b0;
            MemAddress <= '0;
            MemDataOut <= '0;
            MemDataOE  <= 1'b0;
        end else begin
            AckA       <= 1'b0;
            AckB       <= 1'b0;
            RValidA    <= 1'b0;
            RValidB    <= 1'b0;
            MemEnable  <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            MemRefresh <= 1'b0;
            MemAddress <= '0;
            MemDataOut <= '0;
            MemDataOE  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (refresh_start) begin
                        state      <= S_REFRESH;
                        ref_cnt    <= RCNT_LOAD;
                        MemEnable  <= 1'b1;
                        MemRefresh <= 1'b1;
                    end else if (grant_a || grant_b) begin
                        favour_b   <= grant_a;
                        rd_port_b  <= grant_b;
                        AckA       <= grant_a;
                        AckB       <= grant_b;
                        MemEnable  <= 1'b1;
                        MemAddress <= sel_addr;
                        if (sel_write) begin
                            state      <= S_WRITE;
                            MemWrite   <= 1'b1;
                            MemDataOE  <= 1'b1;
                            MemDataOut <= sel_wdata;
                        end else begin
                            state   <= S_READ;
                            MemRead <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    state <= S_IDLE;
                end
                S_READ: begin
                    state   <= S_READ_WAIT;
                    lat_cnt <= LAT_LOAD;
                end
                S_READ_WAIT: begin
                    if (lat_cnt == '0) begin
                        // Capture the bus at the end of the last wait cycle; valid shows in the first IDLE cycle.
                        state <= S_IDLE;
                        if (rd_port_b) begin
                            RDataB  <= MemDataIn;
                            RValidB <= 1'b1;
                        end else begin
                            RDataA  <= MemDataIn;
                            RValidA <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_REFRESH: begin
                    if (ref_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        ref_cnt    <= ref_cnt - RCNT_W'(1);
                        MemEnable  <= 1'b1;
                        MemRefresh <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qsram_access_scheduler.sv
// Bench for qsram_access_scheduler: directed stimulus with a cycle-stamped scoreboard.
// Stimulus pushes expected pin events (with absolute cycle numbers); a negedge monitor pops and compares.
// A second instance with a short interval and long read latency exercises the overrun flag.
module tb_qsram_access_scheduler;

    localparam int AW = 30;
    localparam int DW = 9;

    localparam logic [8:0] F_ACKA = 9'h100;
    localparam logic [8:0] F_ACKB = 9'h080;
    localparam logic [8:0] F_EN   = 9'h040;
    localparam logic [8:0] F_RD   = 9'h020;
    localparam logic [8:0] F_WR   = 9'h010;
    localparam logic [8:0] F_REF  = 9'h008;
    localparam logic [8:0] F_OE   = 9'h004;
    localparam logic [8:0] F_RVA  = 9'h002;
    localparam logic [8:0] F_RVB  = 9'h001;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          ReqA, ReqB, WriteA, WriteB;
    logic [AW-1:0] AddrA, AddrB;
    logic [DW-1:0] WDataA, WDataB;
    logic          AckA, AckB, RValidA, RValidB;
    logic [DW-1:0] RDataA, RDataB;
    logic          MemEnable, MemRead, MemWrite, MemRefresh, MemDataOE;
    logic [AW-1:0] MemAddress;
    logic [DW-1:0] MemDataOut;
    logic [DW-1:0] MemDataIn = 9'h1FF;
    logic          Busy, RefreshOverrun;

    logic          d2_rst;
    logic          d2_req_a;
    logic [AW-1:0] d2_addr_a;
    logic          d2_ack_a, d2_ack_b, d2_rvalid_a, d2_rvalid_b;
    logic [DW-1:0] d2_rdata_a, d2_rdata_b;
    logic          d2_en, d2_rd, d2_wr, d2_ref, d2_oe;
    logic [AW-1:0] d2_maddr;
    logic [DW-1:0] d2_mdout;
    logic          d2_busy, d2_overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            cyc;
        logic [8:0]    flags;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } ev_t;

    ev_t exp_q[$];

    qsram_access_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_INTERVAL(780),
        .REFRESH_CYCLES(4), .READ_LATENCY(2)
    ) u_dut (
        .Clock(Clock), .Reset(Reset),
        .ReqA(ReqA), .ReqB(ReqB), .WriteA(WriteA), .WriteB(WriteB),
        .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
        .AckA(AckA), .AckB(AckB), .RDataA(RDataA), .RDataB(RDataB),
        .RValidA(RValidA), .RValidB(RValidB),
        .MemEnable(MemEnable), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemRefresh(MemRefresh), .MemAddress(MemAddress), .MemDataOut(MemDataOut),
        .MemDataOE(MemDataOE), .MemDataIn(MemDataIn),
        .Busy(Busy), .RefreshOverrun(RefreshOverrun)
    );

    qsram_access_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_INTERVAL(16),
        .REFRESH_CYCLES(2), .READ_LATENCY(40)
    ) u_dut_ovr (
        .Clock(Clock), .Reset(d2_rst),
        .ReqA(d2_req_a), .ReqB(1'b0), .WriteA(1'b0), .WriteB(1'b0),
        .AddrA(d2_addr_a), .AddrB('0), .WDataA('0), .WDataB('0),
        .AckA(d2_ack_a), .AckB(d2_ack_b), .RDataA(d2_rdata_a), .RDataB(d2_rdata_b),
        .RValidA(d2_rvalid_a), .RValidB(d2_rvalid_b),
        .MemEnable(d2_en), .MemRead(d2_rd), .MemWrite(d2_wr),
        .MemRefresh(d2_ref), .MemAddress(d2_maddr), .MemDataOut(d2_mdout),
        .MemDataOE(d2_oe), .MemDataIn(9'h0AB),
        .Busy(d2_busy), .RefreshOverrun(d2_overrun)
    );

    always #5 Clock = ~Clock;

    // Cycle k is the period following the k-th rising edge after reset release.
    always @(posedge Clock or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Device model: returns addr ^ 0x0F3 during the second cycle after MemRead, garbage otherwise.
    int            rd_cmd_cyc = -100;
    logic [AW-1:0] rd_cmd_addr = '0;
    always @(negedge Clock) begin
        if (Reset) rd_cmd_cyc = -100;
        else if (MemRead) begin
            rd_cmd_cyc  = cyc;
            rd_cmd_addr = MemAddress;
        end
        if (!Reset && cyc == rd_cmd_cyc + 2) MemDataIn = rd_cmd_addr[DW-1:0] ^ 9'h0F3;
        else                                 MemDataIn = 9'h1FF;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [8:0] f, input logic [AW-1:0] a,
                           input logic [DW-1:0] w, input logic [DW-1:0] r);
        ev_t e;
        int  i;
        e.cyc = c; e.flags = f; e.addr = a; e.wdata = w; e.rdata = r;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, e);
    endtask

    task automatic push_write(input int c, input bit port_b, input logic [AW-1:0] a, input logic [DW-1:0] w);
        push_ev(c, (port_b ? F_ACKB : F_ACKA) | F_EN | F_WR | F_OE, a, w, '0);
    endtask

    task automatic push_read(input int c, input bit port_b, input logic [AW-1:0] a, input logic [DW-1:0] r);
        push_ev(c, (port_b ? F_ACKB : F_ACKA) | F_EN | F_RD, a, '0, '0);
        push_ev(c + 3, port_b ? F_RVB : F_RVA, '0, '0, r);
    endtask

    task automatic push_refresh(input int c, input int n);
        for (int k = 0; k < n; k++) push_ev(c + k, F_EN | F_REF, '0, '0, '0);
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge Clock);
    endtask

    // Monitor: every cycle with any command, ack or valid activity must match the next expected event.
    ev_t        mon_e;
    logic       mon_ok;
    logic [8:0] mon_f;
    always @(negedge Clock) begin
        if (!Reset) begin
            mon_f = {AckA, AckB, MemEnable, MemRead, MemWrite, MemRefresh, MemDataOE, RValidA, RValidB};
            if (mon_f != 9'h0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected cyc=%0d flags=%b addr=%h", cyc, mon_f, MemAddress);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_ok = (mon_e.cyc == cyc) && (mon_e.flags == mon_f);
                    if ((mon_e.flags & (F_RD | F_WR)) != 9'h0) mon_ok = mon_ok && (MemAddress == mon_e.addr);
                    if ((mon_e.flags & F_WR) != 9'h0)          mon_ok = mon_ok && (MemDataOut == mon_e.wdata);
                    if ((mon_e.flags & F_RVA) != 9'h0)         mon_ok = mon_ok && (RDataA == mon_e.rdata);
                    if ((mon_e.flags & F_RVB) != 9'h0)         mon_ok = mon_ok && (RDataB == mon_e.rdata);
                    if (!mon_ok) begin
                        failures++;
                        $display("FAIL sb_event actual cyc=%0d flags=%b addr=%h wdata=%h rdA=%h rdB=%h expected cyc=%0d flags=%b addr=%h wdata=%h rdata=%h",
                                 cyc, mon_f, MemAddress, MemDataOut, RDataA, RDataB,
                                 mon_e.cyc, mon_e.flags, mon_e.addr, mon_e.wdata, mon_e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d expected run to complete", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; d2_rst = 1'b1;
        ReqA = 0; ReqB = 0; WriteA = 0; WriteB = 0;
        AddrA = '0; AddrB = '0; WDataA = '0; WDataB = '0;
        d2_req_a = 0; d2_addr_a = '0;
        repeat (3) @(negedge Clock);
        check("reset_ctrl", {AckA, AckB, RValidA, RValidB, MemEnable, MemRead, MemWrite,
                             MemRefresh, MemDataOE, Busy, RefreshOverrun}, 64'h0);
        check("reset_data", {RDataA, RDataB, MemDataOut}, 64'h0);
        check("reset_addr", MemAddress, 64'h0);
        Reset = 1'b0;

        // Single write from A.
        at_cycle(10);
        ReqA = 1; WriteA = 1; AddrA = 30'h155; WDataA = 9'h1A5;
        push_write(11, 0, 30'h155, 9'h1A5);
        at_cycle(11);
        check("busy_in_write", Busy, 64'h1);
        ReqA = 0; AddrA = '0; WDataA = '0;
        at_cycle(12);
        check("oe_released", MemDataOE, 64'h0);
        check("busy_after_write", Busy, 64'h0);

        // Single read from B: data returns three cycles after the command.
        at_cycle(20);
        ReqB = 1; WriteB = 0; AddrB = 30'h3;
        push_read(21, 1, 30'h3, 9'h0F0);
        at_cycle(21);
        ReqB = 0;
        at_cycle(22);
        check("busy_in_read_wait", Busy, 64'h1);
        at_cycle(30);
        check("rdatab_hold", RDataB, 64'h0F0);
        check("rdataa_untouched", RDataA, 64'h0);

        // Both ports writing continuously across the first refresh (due at 781).
        at_cycle(770);
        ReqA = 1; WriteA = 1; AddrA = 30'h10; WDataA = 9'h011;
        ReqB = 1; WriteB = 1; AddrB = 30'h20; WDataB = 9'h022;
        push_write(771, 0, 30'h10, 9'h011);
        push_write(773, 1, 30'h20, 9'h022);
        push_write(775, 0, 30'h10, 9'h011);
        push_write(777, 1, 30'h20, 9'h022);
        push_write(779, 0, 30'h10, 9'h011);
        push_refresh(781, 4);
        push_write(786, 1, 30'h20, 9'h022);
        push_write(788, 0, 30'h10, 9'h011);
        push_write(790, 1, 30'h20, 9'h022);
        at_cycle(790);
        ReqA = 0; ReqB = 0;

        // Request first seen in the cycle the second refresh becomes pending.
        at_cycle(1560);
        ReqA = 1; WriteA = 0; AddrA = 30'h2A;
        push_refresh(1561, 4);
        push_read(1566, 0, 30'h2A, 9'h0D9);
        at_cycle(1563);
        check("no_ack_during_refresh", {AckA, Busy}, 64'h1);
        at_cycle(1566);
        ReqA = 0;

        // Reset in the middle of a read wait: no read data may follow.
        at_cycle(1580);
        ReqB = 1; WriteB = 0; AddrB = 30'h7;
        push_ev(1581, F_ACKB | F_EN | F_RD, 30'h7, '0, '0);
        at_cycle(1581);
        ReqB = 0;
        at_cycle(1582);
        check("busy_before_reset", Busy, 64'h1);
        #2 Reset = 1'b1;
        #1 check("reset_in_read_wait", {Busy, MemEnable, MemRead, RValidA, RValidB, AckA, AckB}, 64'h0);
        check("queue_drained_before_reset", exp_q.size(), 64'h0);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        // Reset in the middle of a refresh.
        push_refresh(781, 2);
        at_cycle(782);
        #2 Reset = 1'b1;
        #1 check("reset_in_refresh", {MemEnable, MemRefresh, Busy}, 64'h0);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        // Timer restarts from the full interval after release.
        push_refresh(781, 4);
        at_cycle(790);
        check("refresh_after_reset_drained", exp_q.size(), 64'h0);
        check("no_overrun_main", RefreshOverrun, 64'h0);

        // Overrun: a 40-cycle read wait spans two expiries of a 16-cycle interval.
        @(negedge Clock);
        d2_rst = 1'b0;
        @(negedge Clock);
        d2_req_a = 1; d2_addr_a = 30'h5;
        @(negedge Clock);
        check("ovr_ack", d2_ack_a, 64'h1);
        d2_req_a = 0;
        repeat (18) @(negedge Clock);
        check("ovr_not_yet", {d2_overrun, d2_busy}, 64'h1);
        repeat (13) @(negedge Clock);
        check("ovr_set", d2_overrun, 64'h1);
        repeat (10) @(negedge Clock);
        check("ovr_rvalid", {d2_rvalid_a, d2_rdata_a}, {55'h0, 1'b1, 9'h0AB});
        repeat (57) @(negedge Clock);
        check("ovr_sticky", d2_overrun, 64'h1);
        d2_rst = 1'b1;
        #1 check("ovr_cleared_by_reset", d2_overrun, 64'h0);

        @(negedge Clock);
        check("final_queue_empty", exp_q.size(), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qsram_access_scheduler.md
Name: qsram_access_scheduler

Overview:
- Sequences all accesses to the SDR QSRAM device.
- Arbitrates read/write traffic from two requesters (A, B) and inserts periodic refresh commands from an internal interval timer.
- Sits between the system requesters and the SRAM device pins, and is the only block that drives Enable/Read/Write/Refresh/Address and the data bus output enable.
- Runs on the 100 MHz memory clock.

Parameters:
ADDR_WIDTH, 30, address width for requesters and memory.
DATA_WIDTH, 9, data word width.
REFRESH_INTERVAL, 780, clock cycles between refresh requests (780 cycles = 7.8 us at 100 MHz); must be >= 16.
REFRESH_CYCLES, 4, cycles MemRefresh is held per refresh command; must be >= 1.
READ_LATENCY, 2, cycles from read command to valid MemDataIn; must be >= 1.

Ports:
Clock  in  1  memory clock; all state changes on rising edge.
Reset  in  1  asynchronous, active-high reset.
ReqA / ReqB  in  1  access request; held high until the matching Ack.
WriteA / WriteB  in  1  1 = write, 0 = read; qualified by Req.
AddrA / AddrB  in  ADDR_WIDTH  access address.
WDataA / WDataB  in  DATA_WIDTH  write data.
AckA / AckB  out  1  one-cycle grant pulse.
RDataA / RDataB  out  DATA_WIDTH  read return data; holds its value until the next read for that port.
RValidA / RValidB  out  1  one-cycle read-data-valid pulse.
MemEnable  out  1  device enable.
MemRead  out  1  read command.
MemWrite  out  1  write command.
MemRefresh  out  1  refresh command.
MemAddress  out  ADDR_WIDTH  device address.
MemDataOut  out  DATA_WIDTH  write data driven to the bus.
MemDataOE  out  1  bus output enable; high only in the WRITE state.
MemDataIn  in  DATA_WIDTH  data read from the bus.
Busy  out  1  high whenever the FSM is not in IDLE.
RefreshOverrun  out  1  sticky error flag; cleared only by Reset.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs are 0, including RData*. MemDataOE is released immediately. The refresh counter is loaded with REFRESH_INTERVAL-1, RefreshPending is cleared and the round-robin pointer is set to favour A. An in-flight read is abandoned and no RValid is produced.
- Refresh timer:
  - Free-running down-counter, active in every state.
  - At 0 it sets RefreshPending and reloads with REFRESH_INTERVAL-1.
  - If it reaches 0 while RefreshPending is already set, RefreshOverrun is set and stays high until Reset.
- FSM states: IDLE, WRITE, READ, READ_WAIT, REFRESH.
- IDLE arbitration, evaluated each cycle. Priority is RefreshPending, then requesters.
  - Only one requester active: it is granted.
  - ReqA and ReqB both high: grant the port not served last; the pointer updates on every requester grant.
  - Nothing pending: stay in IDLE with all Mem* outputs 0.
- Grant:
  - Latches address, data and direction, then moves to WRITE or READ.
  - AckX is registered and is high during the single command cycle.
  - The requester may change Req, Addr and WData from the cycle after Ack.
- WRITE (1 cycle): MemEnable=1, MemWrite=1, MemDataOE=1, MemAddress/MemDataOut = latched values. Next state IDLE.
- READ (1 cycle): MemEnable=1, MemRead=1, MemAddress = latched value. Next state READ_WAIT.
- READ_WAIT: all Mem* commands are 0, and the state counts READ_LATENCY cycles.
  - With the command in cycle T, MemDataIn is sampled at the end of cycle T+READ_LATENCY.
  - RDataX updates and RValidX=1 in cycle T+READ_LATENCY+1, which is also the first cycle back in IDLE.
- REFRESH:
  - RefreshPending is cleared on entry.
  - MemEnable=1 and MemRefresh=1 for exactly REFRESH_CYCLES cycles, then IDLE.
  - Requests arriving during REFRESH wait; no Ack is given.
- Throughput and mutual exclusion:
  - Minimum spacing between command cycles is 2: a command is always followed by at least one IDLE cycle.
  - At most one of MemRead/MemWrite/MemRefresh is high in any cycle.
  - AckA and AckB are never high together.
- Refresh timer expiry in the same IDLE cycle as a request: refresh wins that cycle (pending evaluated from the registered flag; expiry in cycle N is visible in N+1).
- A request deasserted before Ack is simply dropped; no Ack is issued.

Test Plan:
- Reset release, no requests, REFRESH_INTERVAL=780, REFRESH_CYCLES=4 -> MemRefresh high for 4 consecutive cycles, first at cycle 781 after reset release, repeating every 780 cycles; all other outputs 0.
- ReqA write, Addr=0x155, WData=0x1A5 in IDLE -> next cycle AckA=1, MemWrite=1, MemDataOE=1, MemAddress=0x155, MemDataOut=0x1A5; MemDataOE=0 the following cycle.
- ReqB read Addr=0x3, model returns 0x0F0 READ_LATENCY=2 cycles after MemRead -> RDataB=0x0F0, RValidB=1 exactly 3 cycles after the command cycle, single pulse.
- ReqA and ReqB held continuously high, both writes -> Acks alternate A,B,A,B with command cycles every 2 cycles; refresh inserted when due without losing any request.
- Request asserted in the same cycle the refresh timer expires -> refresh completes (4 cycles) before Ack for that request; hold RefreshPending by forcing back-to-back long stalls past a second expiry -> RefreshOverrun=1 and stays 1 until Reset.
- Assert Reset during READ_WAIT and during REFRESH -> all outputs 0 immediately (asynchronously), no RValid after release, refresh timer restarts from REFRESH_INTERVAL-1.
